// File: rtl/snn_pkg.sv
// Shared types and helpers for the two-layer LIF network: sequencer states,
// spike-count width and a width-generic saturating add.
package snn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1_ACC,
        ST_L1_FIRE,
        ST_L2_ACC,
        ST_L2_FIRE,
        ST_DONE
    } state_t;

    localparam int SAT_W = 64;

    function automatic int cnt_w(input int t_steps);
        return $clog2(t_steps + 1);
    endfunction

    // Operands arrive sign-extended to SAT_W bits; the result is clamped to the
    // signed range of a w-bit value so that callers can simply truncate it.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w
    );
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] r;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        r  = s;
        if (s > hi) begin
            r = hi;
        end else if (s < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/lif_neuron.sv
// One LIF neuron: bias-seeded accumulator, leak, saturating membrane, threshold.
// Updates only on the strobes it is given; no backpressure of its own.
module lif_neuron
    import snn_pkg::*;
#(
    parameter int N_TERMS = 25,
    parameter int W_W     = 8,
    parameter int W_V     = 16,
    parameter int TH      = 64,
    parameter int LEAK_SH = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           init,
    input  logic           acc_en,
    input  logic           fire,
    input  logic [W_W-1:0] bias,
    input  logic [W_W-1:0] weight,
    input  logic           spk_in,
    output logic           spike
);

    // Bias plus N_TERMS weights cannot overflow this width.
    localparam int W_A = W_W + $clog2(N_TERMS + 1) + 1;

    logic signed [W_A-1:0]   acc_q;
    logic signed [W_A-1:0]   acc_d;
    logic signed [W_V-1:0]   v_q;
    logic signed [W_V-1:0]   v_d;
    logic                    spike_q;
    logic                    spike_d;
    logic signed [SAT_W-1:0] v_ext;
    logic signed [SAT_W-1:0] acc_ext;
    logic signed [SAT_W-1:0] v_new;

    always_comb begin
        acc_d   = acc_q;
        v_d     = v_q;
        spike_d = spike_q;
        v_ext   = {{(SAT_W - W_V){v_q[W_V-1]}}, v_q};
        acc_ext = {{(SAT_W - W_A){acc_q[W_A-1]}}, acc_q};
        v_new   = sat_add(v_ext - (v_ext >>> LEAK_SH), acc_ext, W_V);

        if (clr) begin
            acc_d   = '0;
            v_d     = '0;
            spike_d = 1'b0;
        end else begin
            if (init) begin
                acc_d = {{(W_A - W_W){bias[W_W-1]}}, bias};
            end else if (acc_en && spk_in) begin
                acc_d = acc_q + {{(W_A - W_W){weight[W_W-1]}}, weight};
            end
            if (fire) begin
                if (v_new >= SAT_W'(TH)) begin
                    spike_d = 1'b1;
                    v_d     = '0;
                end else begin
                    spike_d = 1'b0;
                    v_d     = v_new[W_V-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            v_q     <= '0;
            spike_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            v_q     <= v_d;
            spike_q <= spike_d;
        end
    end

    assign spike = spike_q;

endmodule

// File: rtl/snn_lif_net2.sv
// Two-layer time-multiplexed LIF network with per-sample spike counting and argmax.
// One step takes N_IN+N_H+3 cycles; pulse is ignored while busy or while a class is held.
module snn_lif_net2
    import snn_pkg::*;
#(
    parameter int N_IN    = 25,
    parameter int N_H     = 5,
    parameter int N_OUT   = 2,
    parameter int W_W     = 8,
    parameter int W_V     = 16,
    parameter int TH      = 64,
    parameter int LEAK_SH = 3,
    parameter int T_STEPS = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  pulse,
    input  logic                                  clear,
    input  logic [N_IN-1:0]                       total_pixel,
    input  logic [N_H*N_IN*W_W-1:0]               weights_for1,
    input  logic [N_H*W_W-1:0]                    bias_for1,
    input  logic [N_OUT*N_H*W_W-1:0]              weights_for2,
    input  logic [N_OUT*W_W-1:0]                  bias_for2,
    output logic [N_H-1:0]                        spike_l1,
    output logic [N_OUT-1:0]                      spike_l2,
    output logic                                  busy,
    output logic                                  step_done,
    output logic [N_OUT*$clog2(T_STEPS+1)-1:0]    out_count,
    output logic                                  class_valid,
    output logic [$clog2(N_OUT)-1:0]              class_idx
);

    localparam int CW    = cnt_w(T_STEPS);
    localparam int CI_W  = $clog2(N_OUT);
    localparam int IDX_N = (N_IN > N_H) ? N_IN : N_H;
    localparam int IDX_W = (IDX_N > 1) ? $clog2(IDX_N) : 1;

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [N_IN-1:0]   pix_q;
    logic [N_IN-1:0]   pix_d;
    logic [CW-1:0]     step_q;
    logic [CW-1:0]     step_d;
    logic [N_OUT*CW-1:0] cnt_q;
    logic [N_OUT*CW-1:0] cnt_d;
    logic [N_OUT*CW-1:0] cnt_inc;
    logic              cv_q;
    logic              cv_d;
    logic [CI_W-1:0]   ci_q;
    logic [CI_W-1:0]   ci_d;
    logic [CI_W-1:0]   best_i;
    logic [CW-1:0]     best_v;

    logic              accept;
    logic              l1_acc;
    logic              l1_fire;
    logic              l2_init;
    logic              l2_acc;
    logic              l2_fire;
    logic              l1_in;
    logic              l2_in;
    logic [W_W-1:0]    w1_sel [N_H];
    logic [W_W-1:0]    w2_sel [N_OUT];

    assign accept  = (state_q == ST_IDLE) && pulse && !clear && !cv_q;
    assign l1_acc  = (state_q == ST_L1_ACC);
    assign l1_fire = (state_q == ST_L1_FIRE);
    assign l2_init = (state_q == ST_L1_FIRE);
    assign l2_acc  = (state_q == ST_L2_ACC);
    assign l2_fire = (state_q == ST_L2_FIRE);

    // Current input bit and the per-neuron weight for that input index.
    always_comb begin
        l1_in = 1'b0;
        l2_in = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (int'(idx_q) == i) l1_in = pix_q[i];
        end
        for (int h = 0; h < N_H; h++) begin
            if (int'(idx_q) == h) l2_in = spike_l1[h];
        end
        for (int h = 0; h < N_H; h++) begin
            w1_sel[h] = weights_for1[(h * N_IN + int'(idx_q)) * W_W +: W_W];
        end
        for (int o = 0; o < N_OUT; o++) begin
            w2_sel[o] = weights_for2[(o * N_H + int'(idx_q)) * W_W +: W_W];
        end
    end

    // Counts as they would be after this step, and their argmax (lowest index wins ties).
    always_comb begin
        cnt_inc = '0;
        for (int o = 0; o < N_OUT; o++) begin
            cnt_inc[o*CW +: CW] = cnt_q[o*CW +: CW] + CW'(spike_l2[o]);
        end
        best_i = '0;
        best_v = cnt_inc[0 +: CW];
        for (int o = 1; o < N_OUT; o++) begin
            if (cnt_inc[o*CW +: CW] > best_v) begin
                best_v = cnt_inc[o*CW +: CW];
                best_i = CI_W'(o);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pix_d   = pix_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        cv_d    = cv_q;
        ci_d    = ci_q;

        if (clear) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            pix_d   = '0;
            step_d  = '0;
            cnt_d   = '0;
            cv_d    = 1'b0;
            ci_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_L1_ACC;
                        idx_d   = '0;
                        pix_d   = total_pixel;
                    end
                end
                ST_L1_ACC: begin
                    if (idx_q == IDX_W'(N_IN - 1)) begin
                        state_d = ST_L1_FIRE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_L1_FIRE: begin
                    state_d = ST_L2_ACC;
                    idx_d   = '0;
                end
                ST_L2_ACC: begin
                    if (idx_q == IDX_W'(N_H - 1)) begin
                        state_d = ST_L2_FIRE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_L2_FIRE: begin
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    step_d  = step_q + CW'(1);
                    cnt_d   = cnt_inc;
                    if (step_d == CW'(T_STEPS)) begin
                        cv_d = 1'b1;
                        ci_d = best_i;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pix_q   <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            cv_q    <= 1'b0;
            ci_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pix_q   <= pix_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            cv_q    <= cv_d;
            ci_q    <= ci_d;
        end
    end

    for (genvar h = 0; h < N_H; h++) begin : g_l1
        lif_neuron #(
            .N_TERMS (N_IN),
            .W_W     (W_W),
            .W_V     (W_V),
            .TH      (TH),
            .LEAK_SH (LEAK_SH)
        ) u_neuron (
            .clk    (clk),
            .rst    (reset),
            .clr    (clear),
            .init   (accept),
            .acc_en (l1_acc),
            .fire   (l1_fire),
            .bias   (bias_for1[h*W_W +: W_W]),
            .weight (w1_sel[h]),
            .spk_in (l1_in),
            .spike  (spike_l1[h])
        );
    end

    for (genvar o = 0; o < N_OUT; o++) begin : g_l2
        lif_neuron #(
            .N_TERMS (N_H),
            .W_W     (W_W),
            .W_V     (W_V),
            .TH      (TH),
            .LEAK_SH (LEAK_SH)
        ) u_neuron (
            .clk    (clk),
            .rst    (reset),
            .clr    (clear),
            .init   (l2_init),
            .acc_en (l2_acc),
            .fire   (l2_fire),
            .bias   (bias_for2[o*W_W +: W_W]),
            .weight (w2_sel[o]),
            .spk_in (l2_in),
            .spike  (spike_l2[o])
        );
    end

    assign busy        = (state_q != ST_IDLE);
    assign step_done   = (state_q == ST_DONE);
    assign out_count   = cnt_q;
    assign class_valid = cv_q;
    assign class_idx   = ci_q;

endmodule

// File: tb/tb_snn_lif_net2.sv
// Directed bench: instance a (T_STEPS=4) for timing, leak, classification, clear, reset;
// instance b (W_V=12, TH=2047) on the same inputs for saturation.
module tb_snn_lif_net2;

    logic          clk;
    logic          reset;
    logic          pulse;
    logic          clear;
    logic [24:0]   pix;
    logic [999:0]  w1;
    logic [39:0]   b1;
    logic [79:0]   w2;
    logic [15:0]   b2;

    logic [4:0]    a_spike_l1;
    logic [1:0]    a_spike_l2;
    logic          a_busy;
    logic          a_step_done;
    logic [5:0]    a_out_count;
    logic          a_class_valid;
    logic          a_class_idx;

    logic [4:0]    b_spike_l1;
    logic [1:0]    b_spike_l2;
    logic          b_busy;
    logic          b_step_done;
    logic [9:0]    b_out_count;
    logic          b_class_valid;
    logic          b_class_idx;

    int errors = 0;
    int checks = 0;

    snn_lif_net2 #(.T_STEPS(4)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .pulse        (pulse),
        .clear        (clear),
        .total_pixel  (pix),
        .weights_for1 (w1),
        .bias_for1    (b1),
        .weights_for2 (w2),
        .bias_for2    (b2),
        .spike_l1     (a_spike_l1),
        .spike_l2     (a_spike_l2),
        .busy         (a_busy),
        .step_done    (a_step_done),
        .out_count    (a_out_count),
        .class_valid  (a_class_valid),
        .class_idx    (a_class_idx)
    );

    snn_lif_net2 #(.W_V(12), .TH(2047)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .pulse        (pulse),
        .clear        (clear),
        .total_pixel  (pix),
        .weights_for1 (w1),
        .bias_for1    (b1),
        .weights_for2 (w2),
        .bias_for2    (b2),
        .spike_l1     (b_spike_l1),
        .spike_l2     (b_spike_l2),
        .busy         (b_busy),
        .step_done    (b_step_done),
        .out_count    (b_out_count),
        .class_valid  (b_class_valid),
        .class_idx    (b_class_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // One step on instance a or b; checks the pulse-to-step_done latency and
    // returns in IDLE after the DONE cycle.
    task automatic run_step(input bit use_b, input string tag);
        int lat;
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        lat = 0;
        while (((use_b ? b_step_done : a_step_done) !== 1'b1) && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd32);
        tick();
    endtask

    initial begin
        int bcnt;
        int ndone;
        int done_at;

        reset = 1'b1;
        pulse = 1'b0;
        clear = 1'b0;
        pix   = '1;
        w1    = '0;
        b1    = '0;
        w2    = '0;
        b2    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_busy",  64'(a_busy),        64'd0);
        chk("rst_done",  64'(a_step_done),   64'd0);
        chk("rst_s1",    64'(a_spike_l1),    64'd0);
        chk("rst_s2",    64'(a_spike_l2),    64'd0);
        chk("rst_cnt",   64'(a_out_count),   64'd0);
        chk("rst_cv",    64'(a_class_valid), 64'd0);
        chk("rst_ci",    64'(a_class_idx),   64'd0);

        // Latency: busy for 33 cycles, step_done at E0+32, second pulse ignored
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        bcnt = 0;
        ndone = 0;
        done_at = -1;
        for (int k = 0; k < 60; k++) begin
            if (a_busy === 1'b1) bcnt++;
            if (a_step_done === 1'b1) begin
                ndone++;
                done_at = k;
            end
            pulse = (k == 5);
            tick();
        end
        pulse = 1'b0;
        chk("lat_busy_cycles", 64'(bcnt),    64'd33);
        chk("lat_done_at",     64'(done_at), 64'd32);
        chk("lat_done_count",  64'(ndone),   64'd1);

        // Leak/threshold: bias 32 on hidden neuron 0 fires on the third step
        do_clear();
        b1 = 40'd32;
        run_step(1'b0, "leak1");
        chk("leak1_s1", 64'(a_spike_l1), 64'd0);
        run_step(1'b0, "leak2");
        chk("leak2_s1", 64'(a_spike_l1), 64'd0);
        run_step(1'b0, "leak3");
        chk("leak3_s1", 64'(a_spike_l1), 64'h01);
        chk("leak3_cv", 64'(a_class_valid), 64'd0);
        run_step(1'b0, "leak4");
        chk("leak4_s1", 64'(a_spike_l1), 64'd0);
        chk("tie_cv",   64'(a_class_valid), 64'd1);
        chk("tie_ci",   64'(a_class_idx),   64'd0);
        chk("tie_cnt",  64'(a_out_count),   64'd0);

        // Pulse while class_valid is ignored
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        chk("cv_pulse_busy", 64'(a_busy), 64'd0);
        tick();
        chk("cv_pulse_busy2", 64'(a_busy), 64'd0);

        // Classification: output neuron 1 spikes every step, neuron 0 never
        do_clear();
        chk("clr_cv", 64'(a_class_valid), 64'd0);
        b1 = '0;
        b2 = {8'h7f, 8'h80};
        run_step(1'b0, "cls1");
        chk("cls1_s2", 64'(a_spike_l2), 64'b10);
        run_step(1'b0, "cls2");
        chk("cls2_cnt", 64'(a_out_count), 64'd16);
        run_step(1'b0, "cls3");
        chk("cls3_cv", 64'(a_class_valid), 64'd0);
        run_step(1'b0, "cls4");
        chk("cls4_cnt", 64'(a_out_count),   64'd32);
        chk("cls4_cv",  64'(a_class_valid), 64'd1);
        chk("cls4_ci",  64'(a_class_idx),   64'd1);
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        chk("cls_ign_busy", 64'(a_busy), 64'd0);
        repeat (40) tick();
        chk("cls_ign_cnt", 64'(a_out_count), 64'd32);

        // Clear mid-step aborts the step and zeroes potentials and counts
        do_clear();
        b1 = 40'd32;
        run_step(1'b0, "ab1");
        run_step(1'b0, "ab2");
        chk("ab2_cnt", 64'(a_out_count), 64'd16);
        chk("ab2_s2",  64'(a_spike_l2),  64'b10);
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        repeat (9) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("ab_busy", 64'(a_busy),      64'd0);
        chk("ab_cnt",  64'(a_out_count), 64'd0);
        chk("ab_s2",   64'(a_spike_l2),  64'd0);
        bcnt = 0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (a_busy === 1'b1) bcnt++;
            if (a_step_done === 1'b1) ndone++;
            tick();
        end
        chk("ab_no_busy", 64'(bcnt),  64'd0);
        chk("ab_no_done", 64'(ndone), 64'd0);
        pulse = 1'b1;
        clear = 1'b1;
        tick();
        pulse = 1'b0;
        clear = 1'b0;
        chk("clrpulse_busy", 64'(a_busy), 64'd0);
        tick();
        chk("clrpulse_busy2", 64'(a_busy), 64'd0);
        // Hidden potential restarted from 0: 32 < 64, no spike
        run_step(1'b0, "ab3");
        chk("ab3_s1",  64'(a_spike_l1),  64'd0);
        chk("ab3_s2",  64'(a_spike_l2),  64'b10);
        chk("ab3_cnt", 64'(a_out_count), 64'd8);

        // Saturation on instance b (W_V=12, TH=2047)
        do_clear();
        w1 = {125{8'h80}};
        b1 = {5{8'h80}};
        w2 = {10{8'h80}};
        b2 = {2{8'h80}};
        run_step(1'b1, "neg1");
        chk("neg1_s1", 64'(b_spike_l1), 64'd0);
        run_step(1'b1, "neg2");
        chk("neg2_s1", 64'(b_spike_l1), 64'd0);
        w1 = {125{8'h7f}};
        b1 = {5{8'h7f}};
        w2 = {10{8'h7f}};
        b2 = {2{8'h7f}};
        // From -2048: 1510 (no spike), then 4624 clamps to 2047 and fires
        run_step(1'b1, "pos1");
        chk("pos1_s1", 64'(b_spike_l1), 64'd0);
        run_step(1'b1, "pos2");
        chk("pos2_s1", 64'(b_spike_l1), 64'h1f);
        do_clear();
        run_step(1'b1, "pos3");
        chk("pos3_s1", 64'(b_spike_l1), 64'h1f);
        chk("pos3_s2", 64'(b_spike_l2), 64'd0);

        // Asynchronous reset mid-step, then a normal step
        do_clear();
        w1 = '0;
        b1 = '0;
        w2 = '0;
        b2 = {8'h7f, 8'h80};
        run_step(1'b0, "pre_rst");
        chk("pre_rst_cnt", 64'(a_out_count), 64'd8);
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        repeat (10) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", 64'(a_busy),      64'd0);
        chk("arst_s2",   64'(a_spike_l2),  64'd0);
        chk("arst_cnt",  64'(a_out_count), 64'd0);
        chk("arst_done", 64'(a_step_done), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        run_step(1'b0, "post_rst");
        chk("post_rst_s2",  64'(a_spike_l2),  64'b10);
        chk("post_rst_cnt", 64'(a_out_count), 64'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
